// File: rtl/key_mode_latch_pkg.sv
// Shared types and constants for the push-button mode latch.
// Holds debounce FSM encodings, the all-dark code and the default window.
package key_mode_latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } filt_state_e;

  localparam logic [3:0] KEY_OFF    = 4'b1111;
  localparam int         CNT_DB_DEF = 1_000_000;

  // Mode code that pulls only key idx low.
  function automatic logic [3:0] one_hot_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/key_mode_latch_if.sv
// Button-side bus: raw active-low keys in, latched mode code and press strobes out.
interface key_mode_latch_if;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_flag;

  modport master (output key_in, input key_out, input key_flag);
  modport slave  (input key_in, output key_out, output key_flag);
endinterface

// File: rtl/key_mode_latch_filter.sv
// One-button debouncer: 2-FF synchronizer, press/release FSM with window counter.
// fire is the combinational press decision; flag is its registered one-cycle strobe.
module key_filter
  import key_mode_latch_pkg::*;
#(
  parameter int CNT_DB = CNT_DB_DEF,
  parameter int CNT_W  = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic flag,
  output logic fire
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_DB - 1);

  logic [1:0]       sync;
  logic             level;
  filt_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  assign level = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      state <= ST_IDLE;
      cnt   <= '0;
      flag  <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      state <= state_nx;
      cnt   <= cnt_nx;
      flag  <= fire;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (!level) state_nx = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (level) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_PRESSED;
          fire     = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        cnt_nx = '0;
        if (level) state_nx = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        // Release is silent; a bounce simply falls back to PRESSED.
        if (!level) begin
          cnt_nx   = '0;
          state_nx = ST_PRESSED;
        end else if (cnt == CNT_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/key_mode_latch.sv
// Four debounced buttons feeding a sticky one-hot-low mode latch; same key toggles off.
// key_out updates on the edge that raises key_flag; lowest-index press wins a tie.
module key_mode_latch
  import key_mode_latch_pkg::*;
#(
  parameter int CNT_DB = CNT_DB_DEF,
  parameter int CNT_W  = 20
) (
  input logic             clk,
  input logic             rst_n,
  key_mode_latch_if.slave bus
);

  logic [3:0] fire;
  logic [3:0] flag;
  logic [3:0] key_out_q, key_out_nx;

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_filter #(
      .CNT_DB (CNT_DB),
      .CNT_W  (CNT_W)
    ) u_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_raw (bus.key_in[g]),
      .flag    (flag[g]),
      .fire    (fire[g])
    );
  end

  always_comb begin
    logic found;
    found      = 1'b0;
    key_out_nx = key_out_q;
    for (int i = 0; i < 4; i++) begin
      if (fire[i] && !found) begin
        found      = 1'b1;
        key_out_nx = (key_out_q == one_hot_low(2'(i))) ? KEY_OFF : one_hot_low(2'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_out_q <= KEY_OFF;
    else        key_out_q <= key_out_nx;
  end

  assign bus.key_out  = key_out_q;
  assign bus.key_flag = flag;

endmodule

// File: tb/tb_key_mode_latch.sv
// Randomized and scenario bench for key_mode_latch against a run-length button model.
module tb_key_mode_latch;
  import key_mode_latch_pkg::*;

  localparam int DB = 8;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_mode_latch_if bus();

  key_mode_latch #(.CNT_DB(DB), .CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: a key changes debounced state after DB+1 consecutive opposite-level synced samples.
  logic [3:0] m_s1, m_s2, m_dn, m_out, m_flag;
  int         m_run [4];

  logic [3:0] stim[$];
  logic [3:0] obs_flag[$], obs_out[$], exp_flag[$], exp_out[$];

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_dn = 4'h0; m_out = 4'hF; m_flag = 4'h0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] s;
    logic       found;
    logic [3:0] code;
    s = m_s2; m_s2 = m_s1; m_s1 = bus.key_in; m_flag = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (s[i] == m_dn[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DB + 1) begin
          m_run[i] = 0;
          m_dn[i]  = ~m_dn[i];
          if (m_dn[i]) m_flag[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_flag[i] && !found) begin
        found = 1'b1;
        code  = 4'hF ^ 4'(1 << i);
        m_out = (m_out == code) ? 4'hF : code;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.key_in = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Plays stim from a negedge, one value per cycle, recording DUT and model after each edge.
  task automatic run_seq();
    obs_flag.delete(); obs_out.delete(); exp_flag.delete(); exp_out.delete();
    foreach (stim[n]) begin
      bus.key_in = stim[n];
      @(posedge clk);
      model_edge();
      @(negedge clk);
      obs_flag.push_back(bus.key_flag); obs_out.push_back(bus.key_out);
      exp_flag.push_back(m_flag);       exp_out.push_back(m_out);
    end
  endtask

  task automatic push_n(input logic [3:0] v, input int n);
    repeat (n) stim.push_back(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_in = 4'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.key_out !== 4'b1111) begin
      errors++; $display("FAIL reset_key_out got %b want 1111", bus.key_out);
    end
    checks++;
    if (bus.key_flag !== 4'b0000) begin
      errors++; $display("FAIL reset_key_flag got %b want 0000", bus.key_flag);
    end
  endtask

  task automatic test_clean_press();
    int nfl, first;
    apply_reset();
    stim.delete(); push_n(4'b1110, 30); push_n(4'b1111, 30);
    run_seq();
    nfl = 0; first = -1;
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL clean cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
      if (obs_flag[n] != 0) begin
        nfl++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (first != DB + 2 || nfl != 1) begin
      errors++; $display("FAIL clean_timing first flag at %0d count %0d want %0d count 1", first, nfl, DB + 2);
    end
    checks++;
    if (obs_flag[DB + 2] !== 4'b0001 || obs_out[DB + 2] !== 4'b1110) begin
      errors++; $display("FAIL clean_value flag/out %b/%b want 0001/1110", obs_flag[DB + 2], obs_out[DB + 2]);
    end
    checks++;
    if (obs_out[59] !== 4'b1110) begin
      errors++; $display("FAIL clean_hold key_out %b want 1110", obs_out[59]);
    end
  endtask

  task automatic test_bouncy();
    int nfl, first;
    apply_reset();
    stim.delete();
    push_n(4'b1110, 3); push_n(4'b1111, 2); push_n(4'b1110, 4); push_n(4'b1111, 1);
    push_n(4'b1110, 20);
    push_n(4'b1111, 3); push_n(4'b1110, 2); push_n(4'b1111, 20);
    run_seq();
    nfl = 0; first = -1;
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL bouncy cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
      if (obs_flag[n] != 0) begin
        nfl++;
        if (first < 0) first = n;
      end
    end
    checks++;
    if (first != 20 || nfl != 1) begin
      errors++; $display("FAIL bouncy_flags first %0d count %0d want 20 count 1", first, nfl);
    end
    checks++;
    if (obs_out[obs_out.size() - 1] !== 4'b1110) begin
      errors++; $display("FAIL bouncy_out key_out %b want 1110", obs_out[obs_out.size() - 1]);
    end
  endtask

  task automatic test_select_toggle();
    logic [3:0] want [3];
    want[0] = 4'b1011; want[1] = 4'b1101; want[2] = 4'b1111;
    apply_reset();
    stim.delete();
    push_n(4'b1011, 15); push_n(4'b1111, 15);
    push_n(4'b1101, 15); push_n(4'b1111, 15);
    push_n(4'b1101, 15); push_n(4'b1111, 15);
    run_seq();
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL toggle cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
    end
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (obs_out[30 * p + 29] !== want[p]) begin
        errors++; $display("FAIL toggle_step%0d key_out %b want %b", p, obs_out[30 * p + 29], want[p]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int nfl;
    apply_reset();
    stim.delete(); push_n(4'b0101, 20); push_n(4'b1111, 20);
    run_seq();
    nfl = 0;
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL simul cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
      if (obs_flag[n] != 0) nfl++;
    end
    checks++;
    if (obs_flag[DB + 2] !== 4'b1010 || nfl != 1) begin
      errors++; $display("FAIL simul_flag got %b in %0d cycles want 1010 in 1", obs_flag[DB + 2], nfl);
    end
    checks++;
    if (obs_out[39] !== 4'b1101) begin
      errors++; $display("FAIL simul_out key_out %b want 1101", obs_out[39]);
    end
  endtask

  task automatic test_glitch();
    int nfl;
    apply_reset();
    stim.delete();
    push_n(4'b1110, 15); push_n(4'b1111, 15);
    push_n(4'b0111, 7);  push_n(4'b1111, 20);
    run_seq();
    nfl = 0;
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL glitch cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
      if (n >= 30 && obs_flag[n] != 0) nfl++;
    end
    checks++;
    if (nfl != 0 || obs_out[obs_out.size() - 1] !== 4'b1110) begin
      errors++; $display("FAIL glitch_effect flags %0d key_out %b want 0 and 1110", nfl, obs_out[obs_out.size() - 1]);
    end
  endtask

  task automatic test_reset_mid();
    int first;
    apply_reset();
    stim.delete(); push_n(4'b1101, 15); push_n(4'b1111, 15); push_n(4'b1110, 8);
    run_seq();
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL rstmid cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
    end
    // Key0 filter is at count 5 here; reset lands between clock edges.
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.key_out !== 4'b1111 || bus.key_flag !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async flag/out %b/%b want 0000/1111", bus.key_flag, bus.key_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stim.delete(); push_n(4'b1110, 20);
    run_seq();
    first = -1;
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL rstmid_after cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
      if (obs_flag[n] != 0 && first < 0) first = n;
    end
    checks++;
    if (first != DB + 2 || obs_out[19] !== 4'b1110) begin
      errors++; $display("FAIL rstmid_window first flag %0d key_out %b want %0d and 1110", first, obs_out[19], DB + 2);
    end
  endtask

  task automatic test_random();
    int sel;
    logic [3:0] v;
    apply_reset();
    stim.delete();
    while (stim.size() < 3000) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      v = 4'hF;
      else if (sel < 8) v = one_hot_low(2'($urandom_range(0, 3)));
      else              v = 4'($urandom);
      push_n(v, $urandom_range(1, 24));
    end
    run_seq();
    foreach (obs_flag[n]) begin
      checks++;
      if ({obs_flag[n], obs_out[n]} !== {exp_flag[n], exp_out[n]}) begin
        errors++;
        $display("FAIL random cycle %0d flag/out %b/%b want %b/%b", n, obs_flag[n], obs_out[n], exp_flag[n], exp_out[n]);
      end
    end
  endtask

  initial begin
    bus.key_in = 4'hF;
    test_reset();
    test_clean_press();
    test_bouncy();
    test_select_toggle();
    test_simultaneous();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
